// File: rtl/mem_if_pkg.sv
// Shared types and helpers for the instruction-memory responder.
package mem_if_pkg;

  // Returned in place of a real instruction when the fetch address is bad.
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // One response beat as it travels down the latency pipe.
  typedef struct packed {
    logic        valid;
    logic        fault;
    logic [31:0] data;
  } imem_rsp_t;

  localparam int RSP_W = $bits(imem_rsp_t);

  // True when addr lands on a word inside [base, base + 4*depth_words).
  // The explicit >= test catches addresses that wrap below base.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input int unsigned depth_words);
    logic [31:0] off_words;
    off_words = (addr - base) >> 2;
    return (addr >= base) && (off_words < depth_words);
  endfunction

  // Power-of-two test used by the parameter checks.
  function automatic logic is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/imem_responder_rsp_pipe.sv
// Extra latency stages for read responses. Only the valid bits are
// cleared by reset; fault/data are ignored while valid is low.
module imem_rsp_pipe
  import mem_if_pkg::*;
#(
  parameter int STAGES = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [RSP_W-1:0] rsp_i,
  output logic [RSP_W-1:0] rsp_o
);

  if (STAGES < 1) begin : g_bad_stages
    $fatal(1, "imem_rsp_pipe: STAGES must be at least 1");
  end

  imem_rsp_t chain [STAGES+1];

  assign chain[0] = imem_rsp_t'(rsp_i);

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    imem_rsp_t stage_q;
    imem_rsp_t stage_d;

    assign stage_d = chain[gi];

    // Shift one beat per cycle; reset drops every in-flight response
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        stage_q.valid <= 1'b0;
      end else begin
        stage_q.valid <= stage_d.valid;
      end
      stage_q.fault <= stage_d.fault;
      stage_q.data  <= stage_d.data;
    end

    assign chain[gi+1] = stage_q;
  end

  assign rsp_o = chain[STAGES];

endmodule

// File: rtl/imem_responder.sv
// Instruction-fetch memory responder: fixed-latency, fully pipelined reads
// with fault flagging, plus a byte-enabled load port for program images.
module imem_responder
  import mem_if_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS  = 1024,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rd_req,
  input  logic [31:0] rd_ram_addr,
  output logic [31:0] rd_ram_data,
  output logic        rd_valid,
  output logic        rd_fault,
  input  logic        wr_en,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_be,
  output logic        wr_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  // Elaboration-time parameter sanity checks
  if (!is_pow2(DEPTH_WORDS) || (DEPTH_WORDS < 2)) begin : g_bad_depth
    $fatal(1, "imem_responder: DEPTH_WORDS must be a power of two >= 2");
  end
  if ((READ_LATENCY < 1) || (READ_LATENCY > 4)) begin : g_bad_latency
    $fatal(1, "imem_responder: READ_LATENCY must be 1..4");
  end
  if ((BASE_ADDR & ((DEPTH_WORDS << 2) - 1)) != 0) begin : g_bad_base
    $fatal(1, "imem_responder: BASE_ADDR must be aligned to DEPTH_WORDS*4");
  end

  logic [31:0]      mem [DEPTH_WORDS];
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;
  logic             rd_ok;
  logic             rd_en;
  logic             wr_ok;
  logic [31:0]      mem_rd_q;

  // Word index is the low bits of the base-relative offset; range checks
  // decide whether it may be used at all.
  assign rd_idx = IDX_W'((rd_ram_addr - BASE_ADDR) >> 2);
  assign wr_idx = IDX_W'((wr_addr - BASE_ADDR) >> 2);
  assign rd_ok  = addr_in_range(rd_ram_addr, BASE_ADDR, DEPTH_WORDS) &&
                  (rd_ram_addr[1:0] == 2'b00);
  assign rd_en  = rd_req && rd_ok;
  assign wr_ok  = addr_in_range(wr_addr, BASE_ADDR, DEPTH_WORDS);

  // Load port: byte-enabled write; array contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (wr_en && wr_ok) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) begin
          mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  // Registered array read; sees pre-write contents on a same-cycle collision
  always_ff @(posedge clk) begin
    if (rd_en) begin
      mem_rd_q <= mem[rd_idx];
    end
  end

  // First response stage: valid/fault are decided in the request cycle
  logic      s1_valid_q, s1_valid_d;
  logic      s1_fault_q, s1_fault_d;
  imem_rsp_t s1_rsp;

  // Next-state for the first-stage control bits
  always_comb begin
    s1_valid_d = rd_req;
    s1_fault_d = rd_req && !rd_ok;
  end

  // First-stage control register; reset discards the request being accepted
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_fault_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_fault_q <= s1_fault_d;
    end
  end

  // Faulted requests never touched the array, so substitute the NOP here
  always_comb begin
    s1_rsp.valid = s1_valid_q;
    s1_rsp.fault = s1_fault_q;
    s1_rsp.data  = s1_fault_q ? NOP_INST : mem_rd_q;
  end

  imem_rsp_t final_rsp;

  if (READ_LATENCY == 1) begin : g_no_pipe
    assign final_rsp = s1_rsp;
  end else begin : g_pipe
    imem_rsp_pipe #(
      .STAGES (int'(READ_LATENCY) - 1)
    ) u_rsp_pipe (
      .clk     (clk),
      .reset_n (reset_n),
      .rsp_i   (s1_rsp),
      .rsp_o   (final_rsp)
    );
  end

  // Output data holds its last valid value between responses
  logic [31:0] data_hold_q, data_hold_d;

  // Pick fresh response data or keep the previous word
  always_comb begin
    data_hold_d = final_rsp.valid ? final_rsp.data : data_hold_q;
  end

  // Held-data register, cleared to zero by reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_hold_q <= 32'h0;
    end else begin
      data_hold_q <= data_hold_d;
    end
  end

  assign rd_ram_data = data_hold_d;
  assign rd_valid    = final_rsp.valid;
  assign rd_fault    = final_rsp.valid & final_rsp.fault;

  // Dropped-write flag: one-cycle pulse after an out-of-range write strobe
  logic wr_err_q, wr_err_d;

  // An out-of-range strobe is an error regardless of the byte enables
  always_comb begin
    wr_err_d = wr_en && !wr_ok;
  end

  // Error pulse register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_err_q <= 1'b0;
    end else begin
      wr_err_q <= wr_err_d;
    end
  end

  assign wr_err = wr_err_q;

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: three instances (latency 1, latency 3, and
// latency 1 at base 0x1000) driven together and checked against a
// per-instance reference model every cycle, plus directed vectors.
module tb_imem_responder;

  localparam int          DEPTH  = 16;
  localparam logic [31:0] BASE_C = 32'h0000_1000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rd_req = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_be = 4'h0;
  logic [31:0] wr_data = 32'h0;
  logic [31:0] ra [3];
  logic [31:0] wa [3];
  logic [2:0]  v_o, f_o, we_o;
  logic [31:0] d_o [3];

  always #5 clk = ~clk;

  imem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0), .READ_LATENCY(1)) u_l1 (
    .clk(clk), .reset_n(reset_n), .rd_req(rd_req), .rd_ram_addr(ra[0]),
    .rd_ram_data(d_o[0]), .rd_valid(v_o[0]), .rd_fault(f_o[0]),
    .wr_en(wr_en), .wr_addr(wa[0]), .wr_data(wr_data), .wr_be(wr_be), .wr_err(we_o[0]));

  imem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0), .READ_LATENCY(3)) u_l3 (
    .clk(clk), .reset_n(reset_n), .rd_req(rd_req), .rd_ram_addr(ra[1]),
    .rd_ram_data(d_o[1]), .rd_valid(v_o[1]), .rd_fault(f_o[1]),
    .wr_en(wr_en), .wr_addr(wa[1]), .wr_data(wr_data), .wr_be(wr_be), .wr_err(we_o[1]));

  imem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE_C), .READ_LATENCY(1)) u_base (
    .clk(clk), .reset_n(reset_n), .rd_req(rd_req), .rd_ram_addr(ra[2]),
    .rd_ram_data(d_o[2]), .rd_valid(v_o[2]), .rd_fault(f_o[2]),
    .wr_en(wr_en), .wr_addr(wa[2]), .wr_data(wr_data), .wr_be(wr_be), .wr_err(we_o[2]));

  // Reference model state
  typedef struct {
    int          due;
    logic        fault;
    logic [31:0] data;
  } pend_t;

  pend_t       pend [3][$];
  logic [31:0] mm [3][DEPTH];
  logic [31:0] elast [3];
  logic        ewerr [3];
  int          lat [3]  = '{1, 3, 1};
  logic [31:0] base [3] = '{32'h0, 32'h0, BASE_C};
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;

  typedef struct {
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  wbe;
    logic        re;
    logic [31:0] raddr;
    logic        ev;
    logic        ef;
    logic [31:0] ed;
    logic        ewerr;
  } vec_t;

  vec_t tbl [18];

  function automatic logic inr(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] words;
    words = (a - b) >> 2;
    return (a >= b) && (words < DEPTH);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic set_addr(input logic [31:0] r, input logic [31:0] w);
    ra[0] = r;  ra[1] = r;  ra[2] = r + BASE_C;
    wa[0] = w;  wa[1] = w;  wa[2] = w + BASE_C;
  endtask

  // Advance one clock: update the model with this cycle's inputs, then
  // compare every instance against what the model expects after the edge.
  task automatic step();
    logic  rs;
    pend_t r;
    logic  ev, ef;
    int    idx;
    rs = reset_n;
    for (int k = 0; k < 3; k++) begin
      if (!rs) begin
        pend[k].delete();
        ewerr[k] = 1'b0;
      end else begin
        ewerr[k] = wr_en && !inr(wa[k], base[k]);
        if (rd_req) begin
          r.due = cyc + lat[k] - 1;
          r.fault = (ra[k][1:0] != 2'b00) || !inr(ra[k], base[k]);
          if (r.fault) r.data = NOP;
          else         r.data = mm[k][int'((ra[k] - base[k]) >> 2)];
          pend[k].push_back(r);
        end
      end
      if (wr_en && inr(wa[k], base[k])) begin
        idx = int'((wa[k] - base[k]) >> 2);
        for (int b = 0; b < 4; b++)
          if (wr_be[b]) mm[k][idx][8*b +: 8] = wr_data[8*b +: 8];
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      ev = 1'b0;
      ef = 1'b0;
      if (!rs) begin
        elast[k] = 32'h0;
      end else if (pend[k].size() > 0 && pend[k][0].due == cyc) begin
        r = pend[k].pop_front();
        ev = 1'b1;
        ef = r.fault;
        elast[k] = r.data;
      end
      chk($sformatf("model_valid[%0d]", k), 32'(v_o[k]), 32'(ev));
      chk($sformatf("model_fault[%0d]", k), 32'(f_o[k]), 32'(ef));
      chk($sformatf("model_data[%0d]", k), d_o[k], elast[k]);
      chk($sformatf("model_wr_err[%0d]", k), 32'(we_o[k]), 32'(ewerr[k]));
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    rd_req = 1'b0;
    wr_en  = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic logic [31:0] rnd_addr();
    int unsigned sel;
    sel = $urandom_range(0, 9);
    if (sel < 7)       return 32'($urandom_range(0, DEPTH - 1)) << 2;
    else if (sel == 7) return (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
    else if (sel == 8) return 32'(DEPTH * 4) + (32'($urandom_range(0, 3)) << 2);
    else               return $urandom;
  endfunction

  initial begin
    // word 0/1 load, hits, faults, collision, byte enables, dropped write
    tbl[0]  = '{1'b1, 32'h00, 32'h0050_0093, 4'hF, 1'b0, 32'h00, 1'b0, 1'b0, 32'h0000_0000, 1'b0};
    tbl[1]  = '{1'b1, 32'h04, 32'h0010_8113, 4'hF, 1'b0, 32'h00, 1'b0, 1'b0, 32'h0000_0000, 1'b0};
    tbl[2]  = '{1'b0, 32'h00, 32'h0,         4'h0, 1'b1, 32'h00, 1'b1, 1'b0, 32'h0050_0093, 1'b0};
    tbl[3]  = '{1'b0, 32'h00, 32'h0,         4'h0, 1'b1, 32'h04, 1'b1, 1'b0, 32'h0010_8113, 1'b0};
    tbl[4]  = '{1'b0, 32'h00, 32'h0,         4'h0, 1'b0, 32'h00, 1'b0, 1'b0, 32'h0010_8113, 1'b0};
    tbl[5]  = '{1'b0, 32'h00, 32'h0,         4'h0, 1'b1, 32'h02, 1'b1, 1'b1, NOP,           1'b0};
    tbl[6]  = '{1'b0, 32'h00, 32'h0,         4'h0, 1'b1, 32'h40, 1'b1, 1'b1, NOP,           1'b0};
    tbl[7]  = '{1'b1, 32'h14, 32'h1111_1111, 4'hF, 1'b0, 32'h00, 1'b0, 1'b0, NOP,           1'b0};
    tbl[8]  = '{1'b1, 32'h14, 32'hDEAD_BEEF, 4'hF, 1'b1, 32'h14, 1'b1, 1'b0, 32'h1111_1111, 1'b0};
    tbl[9]  = '{1'b0, 32'h00, 32'h0,         4'h0, 1'b1, 32'h14, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0};
    tbl[10] = '{1'b1, 32'h08, 32'hAABB_CCDD, 4'hF, 1'b0, 32'h00, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0};
    tbl[11] = '{1'b1, 32'h08, 32'h1122_3344, 4'h5, 1'b0, 32'h00, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0};
    tbl[12] = '{1'b0, 32'h00, 32'h0,         4'h0, 1'b1, 32'h08, 1'b1, 1'b0, 32'hAA22_CC44, 1'b0};
    tbl[13] = '{1'b1, 32'h08, 32'h5566_7788, 4'h0, 1'b0, 32'h00, 1'b0, 1'b0, 32'hAA22_CC44, 1'b0};
    tbl[14] = '{1'b0, 32'h00, 32'h0,         4'h0, 1'b1, 32'h08, 1'b1, 1'b0, 32'hAA22_CC44, 1'b0};
    tbl[15] = '{1'b1, 32'h40, 32'h1234_5678, 4'hF, 1'b0, 32'h00, 1'b0, 1'b0, 32'hAA22_CC44, 1'b1};
    tbl[16] = '{1'b0, 32'h00, 32'h0,         4'h0, 1'b0, 32'h00, 1'b0, 1'b0, 32'hAA22_CC44, 1'b0};
    tbl[17] = '{1'b0, 32'h00, 32'h0,         4'h0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1, NOP,    1'b0};

    set_addr(32'h0, 32'h0);

    // Reset and check the cleared outputs
    reset_n = 1'b0;
    idle(2);
    chk("reset_valid", 32'(v_o), 32'h0);
    chk("reset_fault", 32'(f_o), 32'h0);
    chk("reset_wr_err", 32'(we_o), 32'h0);
    chk("reset_data0", d_o[0], 32'h0);
    chk("reset_data1", d_o[1], 32'h0);
    reset_n = 1'b1;
    idle(1);

    // Fill the whole array so every later read is defined
    for (int i = 0; i < DEPTH; i++) begin
      set_addr($urandom, 32'(i) << 2);
      wr_en = 1'b1; wr_be = 4'hF; wr_data = 32'hA000_0000 | 32'(i);
      rd_req = 1'b0;
      step();
    end
    wr_en = 1'b0;

    // Directed vectors against the latency-1 instance
    for (int i = 0; i < 18; i++) begin
      wr_en = tbl[i].we; wr_data = tbl[i].wdata; wr_be = tbl[i].wbe;
      rd_req = tbl[i].re;
      set_addr(tbl[i].raddr, tbl[i].waddr);
      step();
      chk($sformatf("tbl%0d_valid", i), 32'(v_o[0]), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d_fault", i), 32'(f_o[0]), 32'(tbl[i].ef));
      chk($sformatf("tbl%0d_data", i), d_o[0], tbl[i].ed);
      chk($sformatf("tbl%0d_wr_err", i), 32'(we_o[0]), 32'(tbl[i].ewerr));
    end

    // Scan read-back after the dropped write
    for (int i = 0; i < DEPTH; i++) begin
      rd_req = 1'b1; wr_en = 1'b0;
      set_addr(32'(i) << 2, 32'h0);
      step();
    end
    idle(3);

    // Base 0x1000 instance: address just below base wraps and must fault
    set_addr(32'h0, 32'h0);
    ra[2] = 32'h0000_0FFC;
    rd_req = 1'b1;
    step();
    chk("below_base_fault", 32'(f_o[2]), 32'h1);
    chk("below_base_data", d_o[2], NOP);
    idle(3);

    // Latency 3: back-to-back hits arrive on consecutive cycles
    rd_req = 1'b1; set_addr(32'h0, 32'h0); step();
    chk("l3_c1_valid", 32'(v_o[1]), 32'h0);
    set_addr(32'h4, 32'h0); step();
    chk("l3_c2_valid", 32'(v_o[1]), 32'h0);
    rd_req = 1'b0; step();
    chk("l3_c3_valid", 32'(v_o[1]), 32'h1);
    chk("l3_c3_data", d_o[1], 32'h0050_0093);
    step();
    chk("l3_c4_valid", 32'(v_o[1]), 32'h1);
    chk("l3_c4_data", d_o[1], 32'h0010_8113);
    step();
    chk("l3_c5_valid", 32'(v_o[1]), 32'h0);
    chk("l3_c5_hold", d_o[1], 32'h0010_8113);

    // Latency 3: reset while three requests are in flight
    idle(3);
    rd_req = 1'b1; set_addr(32'h0, 32'h0); step();
    set_addr(32'h4, 32'h0); step();
    set_addr(32'h8, 32'h0); reset_n = 1'b0; step();
    reset_n = 1'b1; rd_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("flush%0d_valid", i), 32'(v_o[1]), 32'h0);
    end
    rd_req = 1'b1; set_addr(32'h0, 32'h0); step();
    rd_req = 1'b0; step(); step();
    chk("after_flush_valid", 32'(v_o[1]), 32'h1);
    chk("after_flush_data", d_o[1], 32'h0050_0093);
    idle(3);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      reset_n = ($urandom_range(0, 59) != 0);
      rd_req  = ($urandom_range(0, 2) != 0);
      wr_en   = reset_n && ($urandom_range(0, 3) == 0);
      wr_be   = 4'($urandom_range(0, 15));
      wr_data = $urandom;
      set_addr(rnd_addr(), rnd_addr());
      step();
    end
    reset_n = 1'b1;
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
